// File: rtl/lsu_mem_master_if.sv
// SRAM-side bus of the LSU memory master:
// word-addressed, byte-masked strobes with a ready/data return.
interface lsu_mem_master_if;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [14:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_byte_select_o;
  logic        mem_ready_i;
  logic [31:0] mem_data_i;

  modport master (
    output mem_read_o,
    output mem_write_o,
    output mem_addr_o,
    output mem_data_o,
    output mem_byte_select_o,
    input  mem_ready_i,
    input  mem_data_i
  );

  modport slave (
    input  mem_read_o,
    input  mem_write_o,
    input  mem_addr_o,
    input  mem_data_o,
    input  mem_byte_select_o,
    output mem_ready_i,
    output mem_data_i
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Byte/half/word load-store engine for the SRAM wrapper;
// splits word-crossing accesses and extends load results.
module lsu_mem_master (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [1:0]              size_i,
  input  logic                    unsigned_i,
  input  logic [16:0]             addr_i,
  input  logic [31:0]             wdata_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [31:0]             rdata_o,
  lsu_mem_master_if.master        mem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ0,
    S_WAIT0,
    S_REQ1,
    S_WAIT1,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [16:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] d0_q, d0_d;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  k;
  logic [14:0] w;
  logic [3:0]  base;
  logic        split;
  logic [4:0]  sh0;
  logic [5:0]  sh1;
  logic [31:0] lo_src;
  logic [31:0] hi_src;
  logic [31:0] raw;
  logic [31:0] ext;

  assign k   = addr_q[1:0];
  assign w   = addr_q[16:2];
  assign sh0 = {k, 3'b000};
  assign sh1 = 6'd32 - {1'b0, k, 3'b000};

  always_comb begin
    unique case (size_q)
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      default: base = 4'b1111;
    endcase
  end

  assign split = (size_q[1] && (k != 2'd0))
              || ((size_q == 2'b01) && (k == 2'd3));

  // Second-access data only exists in WAIT1; d0 then
  // supplies the low bytes of the reassembled value.
  assign lo_src = (state_q == S_WAIT1) ? d0_q : mem.mem_data_i;
  assign hi_src = (state_q == S_WAIT1) ? mem.mem_data_i : 32'd0;
  assign raw    = (lo_src >> sh0) | (hi_src << sh1);

  always_comb begin
    unique case (size_q)
      2'b00:   ext = {{24{~uns_q & raw[7]}}, raw[7:0]};
      2'b01:   ext = {{16{~uns_q & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 17'd0;
      wdata_q <= 32'd0;
      d0_q    <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      d0_q    <= d0_d;
      rdata_q <= rdata_d;
      if ((state_q == S_IDLE) && req_i) begin
        we_q    <= we_i;
        uns_q   <= unsigned_i;
        size_q  <= size_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
    end
  end

  always_comb begin
    state_d               = state_q;
    d0_d                  = d0_q;
    rdata_d               = rdata_q;
    mem.mem_read_o        = 1'b0;
    mem.mem_write_o       = 1'b0;
    mem.mem_addr_o        = 15'd0;
    mem.mem_data_o        = 32'd0;
    mem.mem_byte_select_o = 4'd0;
    unique case (state_q)
      S_IDLE: begin
        if (req_i) state_d = S_REQ0;
      end
      S_REQ0: begin
        mem.mem_read_o        = ~we_q;
        mem.mem_write_o       = we_q;
        mem.mem_addr_o        = w;
        mem.mem_byte_select_o = base << k;
        mem.mem_data_o        = wdata_q << sh0;
        state_d               = S_WAIT0;
      end
      S_WAIT0: begin
        if (mem.mem_ready_i) begin
          if (split) begin
            d0_d    = mem.mem_data_i;
            state_d = S_REQ1;
          end else begin
            if (!we_q) rdata_d = ext;
            state_d = S_DONE;
          end
        end
      end
      S_REQ1: begin
        mem.mem_read_o        = ~we_q;
        mem.mem_write_o       = we_q;
        mem.mem_addr_o        = w + 15'd1;
        mem.mem_byte_select_o = base >> (3'd4 - {1'b0, k});
        mem.mem_data_o        = wdata_q >> sh1;
        state_d               = S_WAIT1;
      end
      S_WAIT1: begin
        if (mem.mem_ready_i) begin
          if (!we_q) rdata_d = ext;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = (state_q == S_DONE);
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a small
// byte-masked SRAM responder and a manual ready override.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [16:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;

  lsu_mem_master_if bus();

  lsu_mem_master dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .req_i      (req),
    .we_i       (we),
    .size_i     (size),
    .unsigned_i (uns),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .busy_o     (busy),
    .done_o     (done),
    .rdata_o    (rdata),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] sram [0:32767];
  logic        mdl_ready = 1'b0;
  logic [31:0] mdl_data = 32'd0;
  logic [31:0] pend_data = 32'd0;
  logic        pend = 1'b0;
  int          cnt = 0;
  int          waits;
  logic        sram_auto;
  logic        man_ready;
  logic [31:0] man_data;

  assign bus.mem_ready_i = mdl_ready | man_ready;
  assign bus.mem_data_i  = man_ready ? man_data : mdl_data;

  always @(posedge clk) begin
    mdl_ready <= 1'b0;
    if (sram_auto) begin
      if (pend) begin
        if (cnt == 0) begin
          mdl_ready <= 1'b1;
          mdl_data  <= pend_data;
          pend      <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (bus.mem_write_o) begin
        for (int i = 0; i < 4; i++)
          if (bus.mem_byte_select_o[i])
            sram[bus.mem_addr_o][8*i +: 8] <= bus.mem_data_o[8*i +: 8];
      end
      if (bus.mem_read_o || bus.mem_write_o) begin
        if (waits == 0) begin
          mdl_ready <= 1'b1;
          mdl_data  <= sram[bus.mem_addr_o];
        end else begin
          pend      <= 1'b1;
          cnt       <= waits - 1;
          pend_data <= sram[bus.mem_addr_o];
        end
      end
    end
  end

  int          done_cyc;
  int          nstb;
  int          viol;
  logic [14:0] s_addr [4];
  logic [3:0]  s_mask [4];
  logic [31:0] s_data [4];
  logic        s_wr   [4];
  logic [31:0] r_data;

  task automatic do_op(input logic w, input logic [1:0] sz,
                       input logic u, input logic [16:0] a,
                       input logic [31:0] d);
    logic prev_stb;
    logic stb;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    nstb = 0; done_cyc = -1; viol = 0; prev_stb = 1'b0; r_data = '0;
    if (busy) viol++;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      req = 1'b0;
      stb = bus.mem_read_o | bus.mem_write_o;
      if (bus.mem_read_o && bus.mem_write_o) viol++;
      if (stb) begin
        if (prev_stb) viol++;
        if (nstb < 4) begin
          s_addr[nstb] = bus.mem_addr_o;
          s_mask[nstb] = bus.mem_byte_select_o;
          s_data[nstb] = bus.mem_data_o;
          s_wr[nstb]   = bus.mem_write_o;
        end
        nstb++;
      end
      prev_stb = stb;
      if (!busy) viol++;
      if (done) begin
        done_cyc = cyc;
        r_data   = rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
    addr = '0; wdata = '0;
    sram_auto = 1'b1; waits = 0; man_ready = 1'b0; man_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL reset_busy_done: got %b want 00", {busy, done});
    end
    checks++;
    if ({bus.mem_read_o, bus.mem_write_o, bus.mem_byte_select_o} !== 6'd0) begin
      errors++; $display("FAIL reset_strobes: got %b want 0",
        {bus.mem_read_o, bus.mem_write_o, bus.mem_byte_select_o});
    end
    checks++;
    if ({rdata, bus.mem_addr_o, bus.mem_data_o} !== 79'd0) begin
      errors++; $display("FAIL reset_data: rdata %h addr %h data %h want 0",
        rdata, bus.mem_addr_o, bus.mem_data_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_aligned();
    do_op(1'b1, 2'b10, 1'b0, 17'h00010, 32'hDEADBEEF);
    checks++;
    if (done_cyc !== 3) begin
      errors++; $display("FAIL al_st_done: got %0d want 3", done_cyc);
    end
    checks++;
    if (nstb !== 1 || s_wr[0] !== 1'b1 || s_addr[0] !== 15'h0004) begin
      errors++; $display("FAIL al_st_strobe: n %0d wr %b addr %h want 1 1 0004",
        nstb, s_wr[0], s_addr[0]);
    end
    checks++;
    if (s_mask[0] !== 4'b1111 || s_data[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL al_st_lane: mask %b data %h want 1111 deadbeef",
        s_mask[0], s_data[0]);
    end
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL al_st_proto: got %0d violations want 0", viol);
    end
    do_op(1'b0, 2'b10, 1'b0, 17'h00010, 32'd0);
    checks++;
    if (done_cyc !== 3 || r_data !== 32'hDEADBEEF || s_wr[0] !== 1'b0) begin
      errors++; $display("FAIL al_ld: cyc %0d data %h wr %b want 3 deadbeef 0",
        done_cyc, r_data, s_wr[0]);
    end
    do_op(1'b1, 2'b00, 1'b0, 17'h00100, 32'h00000055);
    checks++;
    if (r_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL st_holds_rdata: got %h want deadbeef", r_data);
    end
  endtask

  task automatic test_byte_lanes();
    do_op(1'b1, 2'b10, 1'b0, 17'h00000, 32'h11223380);
    do_op(1'b1, 2'b00, 1'b0, 17'h00002, 32'h000000AB);
    checks++;
    if (s_mask[0] !== 4'b0100 || s_data[0] !== 32'h00AB0000
        || s_addr[0] !== 15'h0000) begin
      errors++; $display("FAIL sb_lane: mask %b data %h addr %h want 0100 00ab0000 0000",
        s_mask[0], s_data[0], s_addr[0]);
    end
    do_op(1'b0, 2'b00, 1'b0, 17'h00000, 32'd0);
    checks++;
    if (r_data !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb_signed: got %h want ffffff80", r_data);
    end
    do_op(1'b0, 2'b01, 1'b1, 17'h00002, 32'd0);
    checks++;
    if (r_data !== 32'h000011AB || s_mask[0] !== 4'b1100) begin
      errors++; $display("FAIL lhu: data %h mask %b want 000011ab 1100",
        r_data, s_mask[0]);
    end
    do_op(1'b0, 2'b01, 1'b0, 17'h00001, 32'd0);
    checks++;
    if (r_data !== 32'hFFFFAB33 || nstb !== 1) begin
      errors++; $display("FAIL lh_signed_k1: data %h n %0d want ffffab33 1",
        r_data, nstb);
    end
  endtask

  task automatic test_misaligned();
    do_op(1'b1, 2'b10, 1'b0, 17'h00003, 32'hA1B2C3D4);
    checks++;
    if (nstb !== 2 || done_cyc !== 5) begin
      errors++; $display("FAIL mis_st_count: n %0d cyc %0d want 2 5", nstb, done_cyc);
    end
    checks++;
    if (s_addr[0] !== 15'h0000 || s_mask[0] !== 4'b1000
        || s_data[0] !== 32'hD4000000) begin
      errors++; $display("FAIL mis_acc0: addr %h mask %b data %h want 0000 1000 d4000000",
        s_addr[0], s_mask[0], s_data[0]);
    end
    checks++;
    if (s_addr[1] !== 15'h0001 || s_mask[1] !== 4'b0111
        || s_data[1] !== 32'h00A1B2C3) begin
      errors++; $display("FAIL mis_acc1: addr %h mask %b data %h want 0001 0111 00a1b2c3",
        s_addr[1], s_mask[1], s_data[1]);
    end
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL mis_proto: got %0d violations want 0", viol);
    end
    do_op(1'b0, 2'b10, 1'b0, 17'h00003, 32'd0);
    checks++;
    if (r_data !== 32'hA1B2C3D4 || done_cyc !== 5) begin
      errors++; $display("FAIL mis_ld: data %h cyc %0d want a1b2c3d4 5",
        r_data, done_cyc);
    end
    do_op(1'b0, 2'b11, 1'b0, 17'h00003, 32'd0);
    checks++;
    if (r_data !== 32'hA1B2C3D4 || nstb !== 2) begin
      errors++; $display("FAIL size11_word: data %h n %0d want a1b2c3d4 2",
        r_data, nstb);
    end
  endtask

  task automatic test_wrap();
    do_op(1'b1, 2'b00, 1'b0, 17'h1FFFF, 32'h00000034);
    checks++;
    if (s_addr[0] !== 15'h7FFF || s_mask[0] !== 4'b1000
        || s_data[0] !== 32'h34000000) begin
      errors++; $display("FAIL wrap_sb: addr %h mask %b data %h want 7fff 1000 34000000",
        s_addr[0], s_mask[0], s_data[0]);
    end
    do_op(1'b1, 2'b00, 1'b0, 17'h00000, 32'h00000012);
    do_op(1'b0, 2'b01, 1'b1, 17'h1FFFF, 32'd0);
    checks++;
    if (nstb !== 2 || s_addr[0] !== 15'h7FFF || s_addr[1] !== 15'h0000) begin
      errors++; $display("FAIL wrap_addr: n %0d a0 %h a1 %h want 2 7fff 0000",
        nstb, s_addr[0], s_addr[1]);
    end
    checks++;
    if (s_mask[0] !== 4'b1000 || s_mask[1] !== 4'b0001) begin
      errors++; $display("FAIL wrap_mask: m0 %b m1 %b want 1000 0001",
        s_mask[0], s_mask[1]);
    end
    checks++;
    if (r_data !== 32'h00001234 || done_cyc !== 5) begin
      errors++; $display("FAIL wrap_data: data %h cyc %0d want 00001234 5",
        r_data, done_cyc);
    end
  endtask

  task automatic test_wait_states();
    waits = 2;
    do_op(1'b0, 2'b10, 1'b0, 17'h00010, 32'd0);
    checks++;
    if (done_cyc !== 5 || r_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wait2_ld: cyc %0d data %h want 5 deadbeef",
        done_cyc, r_data);
    end
    waits = 1;
    do_op(1'b0, 2'b10, 1'b0, 17'h00003, 32'd0);
    checks++;
    if (done_cyc !== 7 || r_data !== 32'hA1B2C3D4) begin
      errors++; $display("FAIL wait1_split: cyc %0d data %h want 7 a1b2c3d4",
        done_cyc, r_data);
    end
    waits = 0;
  endtask

  task automatic test_reset_mid();
    int ndone;
    ndone = 0;
    sram_auto = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 17'h00003;
    @(negedge clk);
    req = 1'b0;
    checks++;
    if (bus.mem_read_o !== 1'b1) begin
      errors++; $display("FAIL rm_req0: read %b want 1", bus.mem_read_o);
    end
    @(negedge clk);
    man_ready = 1'b1; man_data = 32'h01020304;
    @(negedge clk);
    man_ready = 1'b0;
    checks++;
    if (bus.mem_read_o !== 1'b1 || bus.mem_addr_o !== 15'h0001) begin
      errors++; $display("FAIL rm_req1: read %b addr %h want 1 0001",
        bus.mem_read_o, bus.mem_addr_o);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, bus.mem_read_o, bus.mem_write_o,
         bus.mem_byte_select_o} !== 8'd0) begin
      errors++; $display("FAIL rm_ctrl_zero: got %b want 0",
        {busy, done, bus.mem_read_o, bus.mem_write_o, bus.mem_byte_select_o});
    end
    checks++;
    if ({rdata, bus.mem_addr_o, bus.mem_data_o} !== 79'd0) begin
      errors++; $display("FAIL rm_data_zero: rdata %h addr %h data %h want 0",
        rdata, bus.mem_addr_o, bus.mem_data_o);
    end
    rst_n = 1'b1;
    man_ready = 1'b1; man_data = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      man_ready = 1'b0;
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++; $display("FAIL rm_late_ready: got %0d active cycles want 0", ndone);
    end
    sram_auto = 1'b1;
    do_op(1'b0, 2'b10, 1'b0, 17'h00010, 32'd0);
    checks++;
    if (done_cyc !== 3 || r_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rm_recover: cyc %0d data %h want 3 deadbeef",
        done_cyc, r_data);
    end
  endtask

  task automatic test_busy_req();
    int ndone;
    int nst;
    int nwr;
    int dcyc;
    logic [14:0] badr;
    logic [31:0] dval;
    ndone = 0; nst = 0; nwr = 0; dcyc = -1; badr = '0; dval = '0;
    waits = 2;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0;
    addr = 17'h00010; wdata = 32'd0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      req = 1'b0;
      if (bus.mem_read_o || bus.mem_write_o) begin
        nst++;
        badr = bus.mem_addr_o;
      end
      if (bus.mem_write_o) nwr++;
      if (done) begin
        ndone++;
        dcyc = cyc;
        dval = rdata;
      end
      if (cyc == 2) begin
        req = 1'b1; we = 1'b1; addr = 17'h00003; wdata = 32'h55555555;
      end
    end
    waits = 0; we = 1'b0;
    checks++;
    if (ndone !== 1 || dcyc !== 5) begin
      errors++; $display("FAIL busy_req_done: n %0d cyc %0d want 1 5", ndone, dcyc);
    end
    checks++;
    if (nst !== 1 || nwr !== 0 || badr !== 15'h0004) begin
      errors++; $display("FAIL busy_req_bus: strobes %0d writes %0d addr %h want 1 0 0004",
        nst, nwr, badr);
    end
    checks++;
    if (dval !== 32'hDEADBEEF) begin
      errors++; $display("FAIL busy_req_data: got %h want deadbeef", dval);
    end
  endtask

  task automatic test_back_to_back();
    do_op(1'b0, 2'b10, 1'b0, 17'h00010, 32'd0);
    checks++;
    if (done_cyc !== 3 || r_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL b2b_first: cyc %0d data %h want 3 deadbeef",
        done_cyc, r_data);
    end
    do_op(1'b0, 2'b01, 1'b1, 17'h00002, 32'd0);
    checks++;
    if (done_cyc !== 3 || r_data !== 32'h0000D4AB || viol !== 0) begin
      errors++; $display("FAIL b2b_second: cyc %0d data %h viol %0d want 3 0000d4ab 0",
        done_cyc, r_data, viol);
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_byte_lanes();
    test_misaligned();
    test_wrap();
    test_wait_states();
    test_reset_mid();
    test_busy_req();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
